prog_sequence_generator: RTL and testbench
==========================================

PROG_SEQUENCE_GENERATOR -- requirements
Module: prog_sequence_generator

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each sequence value.
REQ-002 Parameter DEPTH, default 8: maximum sequence length in entries, DEPTH >= 2.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 load_en  input  1  write load_data into the next free table entry.
REQ-006 load_data  input  WIDTH  value to append to the sequence.
REQ-007 clear  input  1  discard the loaded sequence; length returns to 0.
REQ-008 start  input  1  begin stepping through the loaded sequence.
REQ-009 stop  input  1  end stepping; the table is retained.
REQ-010 hold  input  1  freeze the current position while running.
REQ-011 dir  input  1  direction: 0 = ascending index, 1 = descending index.
REQ-012 seq_out  output  WIDTH  registered current sequence value.
REQ-013 seq_next  output  WIDTH  value that seq_out will take at the next advance.
REQ-014 index  output  clog2(DEPTH)  position of seq_out in the table.
REQ-015 length  output  clog2(DEPTH)+1  number of loaded entries.
REQ-016 running  output  1  high while in the RUN state.
REQ-017 wrap  output  1  single-cycle pulse when the sequence restarts.
REQ-018 full  output  1  high when length == DEPTH.

Function
REQ-019 The FSM SHALL have exactly two states, IDLE and RUN, and running SHALL equal (state == RUN).
REQ-020 In IDLE, when load_en is high and full is low, the block SHALL write load_data to table[length] and increment length by 1; load_en SHALL be ignored while full is high.
REQ-021 load_en and clear SHALL be ignored in RUN.
REQ-022 In IDLE, clear SHALL set length to 0 and SHALL take priority over load_en in the same cycle.
REQ-023 In IDLE, start with length == 0 SHALL be ignored.
REQ-024 In IDLE, start with length >= 1 SHALL move the FSM to RUN on the next edge, with index = 0 if dir = 0, or index = length-1 if dir = 1, and seq_out = table[that index] on the same edge.
REQ-025 In RUN with hold low, each edge SHALL step index by +1 (dir = 0) or -1 (dir = 1), modulo length, and SHALL load seq_out with table[new index].
REQ-026 When hold is high in RUN, index and seq_out SHALL be unchanged.
REQ-027 wrap SHALL be high for the one cycle after an edge on which index steps from length-1 to 0 (dir = 0) or from 0 to length-1 (dir = 1); otherwise wrap SHALL be 0.
REQ-028 A change of dir in RUN SHALL take effect at the next advance, with no skipped or repeated entry beyond the reversal.
REQ-029 seq_next SHALL be combinational: table[index stepped per the current dir]; it SHALL equal seq_out when length == 1.
REQ-030 With length == 1, every advance SHALL wrap, holding index at 0 and pulsing wrap on every advancing cycle.
REQ-031 stop in RUN SHALL return the FSM to IDLE on the next edge; seq_out and index SHALL hold their last values.
REQ-032 When start and stop are both high in the same cycle, stop SHALL win.
REQ-033 In IDLE, seq_out and index SHALL be held.

Reset
REQ-034 On reset, the block SHALL set state = IDLE, length = 0, index = 0, seq_out = 0 and wrap = 0, and SHALL clear every table entry to 0.
REQ-035 Reset SHALL override every other input in the same cycle, including during RUN.

Structure
REQ-036 Package prog_seq_pkg SHALL hold the state encoding (IDLE = 0, RUN = 1) and the dir constants (DIR_UP = 0, DIR_DOWN = 1).
REQ-037 The table SHALL be a sub-module, seq_table, with one write port and two combinational read ports (current and next); the FSM, index and length logic SHALL stay in the top module.

Verification
REQ-038 Load 0, 8, 5, 3, 7, 2 and start with dir = 0 -> seq_out = 0, 8, 5, 3, 7, 2, 0, 8 on successive cycles, with wrap high only in the cycle showing the second 0.
REQ-039 Same table, start with dir = 1 -> seq_out = 2, 7, 3, 5, 8, 0, 2, with wrap high when 2 reappears; toggle dir while seq_out = 3 -> the next values are 7, 2.
REQ-040 Load DEPTH + 2 values -> length = DEPTH, full = 1, and the extra writes are ignored; clear together with load_en -> length = 0.
REQ-041 Assert hold for 3 cycles while running -> seq_out and index stay frozen; assert start and stop together in RUN -> IDLE, with seq_out held.
REQ-042 Assert reset mid-RUN -> on the next cycle state = IDLE, seq_out = 0 and length = 0; a later start is ignored until a new load.
REQ-043 Load one value, 9, and start -> seq_out = 9 every cycle, wrap pulses every cycle, and seq_next = 9.

Source files
------------

// File: rtl/prog_sequence_generator_pkg.sv
// rtl/prog_sequence_generator_pkg.sv - shared state and direction encodings
package prog_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_sequence_generator_if.sv
// rtl/prog_sequence_generator_if.sv - control and observation bundle of the sequence generator
interface prog_sequence_generator_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             clear;
  logic             start;
  logic             stop;
  logic             hold;
  logic             dir;
  logic [WIDTH-1:0] seq_out;
  logic [WIDTH-1:0] seq_next;
  logic [IW-1:0]    index;
  logic [IW:0]      length;
  logic             running;
  logic             wrap;
  logic             full;

  modport master (
    output load_en, load_data, clear, start, stop, hold, dir,
    input  seq_out, seq_next, index, length, running, wrap, full
  );

  modport slave (
    input  load_en, load_data, clear, start, stop, hold, dir,
    output seq_out, seq_next, index, length, running, wrap, full
  );
endinterface

// File: rtl/prog_sequence_generator_seq_table.sv
// rtl/prog_sequence_generator_seq_table.sv - value table with one write port and two combinational read ports
module seq_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    cur_addr,
  output logic [WIDTH-1:0] cur_data,
  input  logic [AW-1:0]    next_addr,
  output logic [WIDTH-1:0] next_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign cur_data  = mem[cur_addr];
  assign next_data = mem[next_addr];
endmodule

// File: rtl/prog_sequence_generator.sv
// rtl/prog_sequence_generator.sv - programmable sequence generator: IDLE/RUN FSM, index and length control
module prog_sequence_generator
  import prog_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input logic                     clock,
  input logic                     reset,
  prog_sequence_generator_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  state_t           state, state_nxt;
  logic [IW-1:0]    index_q, len_last, step_idx, start_idx, cur_addr;
  logic [LW-1:0]    length_q;
  logic [WIDTH-1:0] seq_q, rd_cur, rd_next;
  logic             wrap_q, full_w, do_load, do_start, do_step, step_wraps;

  assign full_w   = (length_q == LW'(DEPTH));
  assign len_last = IW'(length_q - LW'(1));

  // Neighbour of index in the current direction; seq_next reads from here
  always_comb begin
    step_idx   = index_q;
    step_wraps = 1'b0;
    if (bus.dir == DIR_UP) begin
      if (index_q == len_last) begin
        step_idx   = '0;
        step_wraps = 1'b1;
      end else begin
        step_idx = index_q + IW'(1);
      end
    end else begin
      if (index_q == '0) begin
        step_idx   = len_last;
        step_wraps = 1'b1;
      end else begin
        step_idx = index_q - IW'(1);
      end
    end
  end

  assign start_idx = (bus.dir == DIR_DOWN) ? len_last : '0;
  assign cur_addr  = (state == IDLE) ? start_idx : index_q;

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_start  = 1'b0;
    do_step   = 1'b0;
    case (state)
      IDLE: begin
        do_load = bus.load_en && !bus.clear && !full_w;
        if (bus.start && !bus.stop && !bus.clear && (length_q != '0)) begin
          state_nxt = RUN;
          do_start  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) state_nxt = IDLE;
        else          do_step   = !bus.hold;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      length_q <= '0;
      index_q  <= '0;
      seq_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wrap_q <= do_step && step_wraps;
      if (state == IDLE && bus.clear) length_q <= '0;
      else if (do_load)               length_q <= length_q + LW'(1);
      if (do_start) begin
        index_q <= start_idx;
        seq_q   <= rd_cur;
      end else if (do_step) begin
        index_q <= step_idx;
        seq_q   <= rd_next;
      end
    end
  end

  seq_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(IW)) u_table (
    .clock     (clock),
    .reset     (reset),
    .we        (do_load),
    .waddr     (IW'(length_q)),
    .wdata     (bus.load_data),
    .cur_addr  (cur_addr),
    .cur_data  (rd_cur),
    .next_addr (step_idx),
    .next_data (rd_next)
  );

  assign bus.seq_out  = seq_q;
  assign bus.seq_next = rd_next;
  assign bus.index    = index_q;
  assign bus.length   = length_q;
  assign bus.running  = (state == RUN);
  assign bus.wrap     = wrap_q;
  assign bus.full     = full_w;
endmodule

// File: tb/tb_prog_sequence_generator.sv
// tb/tb_prog_sequence_generator.sv - directed self-checking bench for prog_sequence_generator
module tb_prog_sequence_generator;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  int up_exp [9] = '{0, 8, 5, 3, 7, 2, 0, 8, 5};
  int dn_exp [9] = '{2, 7, 3, 5, 8, 0, 2, 7, 3};

  prog_sequence_generator_if #(.WIDTH(4), .DEPTH(8)) bus ();

  prog_sequence_generator #(.WIDTH(4), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic load_one(input int v);
    bus.load_en   = 1'b1;
    bus.load_data = 4'(v);
    @(negedge clock);
    bus.load_en   = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
  endtask

  task automatic load_base();
    do_clear();
    load_one(0); load_one(8); load_one(5); load_one(3); load_one(7); load_one(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.seq_out !== 4'd0) begin errors++; $display("FAIL reset_seq_out: got %0d want 0", bus.seq_out); end
    checks++; if (bus.index !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", bus.index); end
    checks++; if (bus.length !== 4'd0) begin errors++; $display("FAIL reset_length: got %0d want 0", bus.length); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", bus.running); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b want 0", bus.wrap); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", bus.full); end
  endtask

  task automatic test_up();
    load_base();
    checks++; if (bus.length !== 4'd6) begin errors++; $display("FAIL up_length: got %0d want 6", bus.length); end
    bus.dir = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.seq_out !== 4'(up_exp[i])) begin errors++; $display("FAIL up_seq_out[%0d]: got %0d want %0d", i, bus.seq_out, up_exp[i]); end
      checks++; if (bus.wrap !== (i == 6)) begin errors++; $display("FAIL up_wrap[%0d]: got %0b want %0b", i, bus.wrap, i == 6); end
      checks++; if (bus.seq_next !== 4'(up_exp[i+1])) begin errors++; $display("FAIL up_seq_next[%0d]: got %0d want %0d", i, bus.seq_next, up_exp[i+1]); end
      @(negedge clock);
    end
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL up_stop_running: got %0b want 0", bus.running); end
    checks++; if (bus.seq_out !== 4'd5) begin errors++; $display("FAIL up_stop_seq_out: got %0d want 5", bus.seq_out); end
    @(negedge clock);
    checks++; if (bus.index !== 3'd2) begin errors++; $display("FAIL idle_index_held: got %0d want 2", bus.index); end
  endtask

  task automatic test_down_reverse();
    bus.dir = 1'b1; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.seq_out !== 4'(dn_exp[i])) begin errors++; $display("FAIL dn_seq_out[%0d]: got %0d want %0d", i, bus.seq_out, dn_exp[i]); end
      checks++; if (bus.wrap !== (i == 6)) begin errors++; $display("FAIL dn_wrap[%0d]: got %0b want %0b", i, bus.wrap, i == 6); end
      if (i < 8) @(negedge clock);
    end
    bus.dir = 1'b0;
    #1;
    checks++; if (bus.seq_next !== 4'd7) begin errors++; $display("FAIL rev_seq_next: got %0d want 7", bus.seq_next); end
    @(negedge clock);
    checks++; if (bus.seq_out !== 4'd7) begin errors++; $display("FAIL rev_first: got %0d want 7", bus.seq_out); end
    @(negedge clock);
    checks++; if (bus.seq_out !== 4'd2) begin errors++; $display("FAIL rev_second: got %0d want 2", bus.seq_out); end
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
  endtask

  task automatic test_hold();
    bus.dir = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.hold = 1'b1; bus.clear = 1'b1; bus.load_en = 1'b1; bus.load_data = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (bus.seq_out !== 4'd8) begin errors++; $display("FAIL hold_seq_out[%0d]: got %0d want 8", i, bus.seq_out); end
      checks++; if (bus.index !== 3'd1) begin errors++; $display("FAIL hold_index[%0d]: got %0d want 1", i, bus.index); end
    end
    bus.hold = 1'b0; bus.clear = 1'b0; bus.load_en = 1'b0;
    checks++; if (bus.length !== 4'd6) begin errors++; $display("FAIL run_ignores_clear_load: got %0d want 6", bus.length); end
    @(negedge clock);
    checks++; if (bus.seq_out !== 4'd5) begin errors++; $display("FAIL hold_release: got %0d want 5", bus.seq_out); end
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL start_stop_running: got %0b want 0", bus.running); end
    checks++; if (bus.seq_out !== 4'd5) begin errors++; $display("FAIL start_stop_seq_out: got %0d want 5", bus.seq_out); end
  endtask

  task automatic test_reset_mid_run();
    bus.dir = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL mid_reset_running: got %0b want 0", bus.running); end
    checks++; if (bus.seq_out !== 4'd0) begin errors++; $display("FAIL mid_reset_seq_out: got %0d want 0", bus.seq_out); end
    checks++; if (bus.length !== 4'd0) begin errors++; $display("FAIL mid_reset_length: got %0d want 0", bus.length); end
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL empty_start_running: got %0b want 0", bus.running); end
  endtask

  task automatic test_full();
    do_clear();
    for (int v = 1; v <= 10; v++) load_one(v);
    checks++; if (bus.length !== 4'd8) begin errors++; $display("FAIL full_length: got %0d want 8", bus.length); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b want 1", bus.full); end
    bus.dir = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.seq_out !== 4'((i % 8) + 1)) begin errors++; $display("FAIL full_seq_out[%0d]: got %0d want %0d", i, bus.seq_out, (i % 8) + 1); end
      @(negedge clock);
    end
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    bus.clear = 1'b1; bus.load_en = 1'b1; bus.load_data = 4'd5;
    @(negedge clock);
    bus.clear = 1'b0; bus.load_en = 1'b0;
    checks++; if (bus.length !== 4'd0) begin errors++; $display("FAIL clear_priority_length: got %0d want 0", bus.length); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL clear_full: got %0b want 0", bus.full); end
  endtask

  task automatic test_single();
    load_one(9);
    bus.dir = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.seq_out !== 4'd9) begin errors++; $display("FAIL single_seq_out[%0d]: got %0d want 9", i, bus.seq_out); end
      checks++; if (bus.seq_next !== 4'd9) begin errors++; $display("FAIL single_seq_next[%0d]: got %0d want 9", i, bus.seq_next); end
      checks++; if (bus.index !== 3'd0) begin errors++; $display("FAIL single_index[%0d]: got %0d want 0", i, bus.index); end
      checks++; if (bus.wrap !== (i > 0)) begin errors++; $display("FAIL single_wrap[%0d]: got %0b want %0b", i, bus.wrap, i > 0); end
      @(negedge clock);
    end
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.load_en = 1'b0; bus.load_data = '0; bus.clear = 1'b0; bus.start = 1'b0;
    bus.stop = 1'b0; bus.hold = 1'b0; bus.dir = 1'b0;
    test_reset();
    test_up();
    test_down_reverse();
    test_hold();
    test_reset_mid_run();
    test_full();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
